raymarch_frame_scheduler: RTL and testbench
===========================================

RAYMARCH_FRAME_SCHEDULER -- requirements
Module: raymarch_frame_scheduler

Interface
REQ-001 Parameter LATENCY, default 32: fixed clock latency from raymarcher pixel_x/pixel_y input to red/green/blue output, 1..255.
REQ-002 Parameter FIFO_DEPTH, default 64: result FIFO entries; power of two, >= LATENCY+1.
REQ-003 Parameters H_RES 640, V_RES 480: frame dimensions in pixels.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle request to render one frame.
REQ-007 look_at_1_1..look_at_3_3, eye_x, eye_y, eye_z  in  27 each  camera parameters, 27-bit float.
REQ-008 busy  out  1  frame in progress.
REQ-009 frame_done  out  1  one-cycle pulse after the last pixel write is accepted.
REQ-010 rm_pixel_x / rm_pixel_y  out  10 / 10  pixel coordinate to the raymarcher.
REQ-011 rm_look_at_*, rm_eye_*  out  27 each  frame-stable shadow copies of the camera parameters.
REQ-012 rm_red, rm_green, rm_blue  in  8 each  raymarcher colour result.
REQ-013 fb_wr_valid  out  1; fb_wr_ready  in  1  frame-buffer write handshake.
REQ-014 fb_wr_addr  out  19  linear address y*H_RES+x; fb_wr_data  out  24  {red,green,blue}.

Function
REQ-015 States: IDLE, RUN, DRAIN, DONE; reset enters IDLE.
REQ-016 IDLE: start=1 latches all 12 camera inputs into shadow registers, zeroes the issue and write counters, and moves to RUN next cycle; start in any other state is ignored.
REQ-017 Shadow registers change only on an accepted start; camera inputs are don't-care at all other times.
REQ-018 Issue: in RUN, one pixel per cycle when inflight+fifo_count < FIFO_DEPTH (credit rule); inflight = valid bits set in the delay line.
REQ-019 Issue order is raster: x 0..H_RES-1, then y+1; x wraps to 0 at H_RES-1.
REQ-020 rm_pixel_x/y hold their last value on non-issue cycles.
REQ-021 A LATENCY-deep valid shift register tags issued pixels; a valid bit at the tail pushes {rm_red,rm_green,rm_blue} into the FIFO that same cycle.
REQ-022 The credit rule guarantees the FIFO never overflows; a push into a full FIFO is a design error, flagged by an assertion.
REQ-023 fb_wr_valid = FIFO not empty; fb_wr_data = FIFO head; a write is accepted on fb_wr_valid and fb_wr_ready in the same cycle.
REQ-024 fb_wr_addr comes from a write counter starting at 0 and incrementing by 1 per accepted write; results arrive in order, so no address travels with the pipeline.
REQ-025 Simultaneous push and pop leave fifo_count unchanged; a push into an empty FIFO is visible at the head the next cycle.
REQ-026 Issuing pixel (H_RES-1, V_RES-1) moves RUN to DRAIN; no further issues.
REQ-027 DRAIN to DONE when the write counter reaches H_RES*V_RES (307200); DONE pulses frame_done for one cycle, then returns to IDLE.
REQ-028 busy = 1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-029 fb_wr_ready held low indefinitely: issue stalls via credits, no data is lost, and fb_wr_valid and fb_wr_data stay stable while unaccepted.

Reset
REQ-030 With rst_n low at a clock edge, the next cycle shows state IDLE, busy=0, frame_done=0, fb_wr_valid=0, fb_wr_addr=0, rm_pixel_x=rm_pixel_y=0, all shadow registers 0, the delay line cleared and the FIFO empty.
REQ-031 Reset mid-frame discards all in-flight and queued results; no fb write occurs after reset until a new start.

Verification
REQ-032 Reset, start, fb_wr_ready=1 constant, model raymarcher as LATENCY=32 delay of colour=f(x,y) -> 307200 writes, addresses 0..307199 in order, data matches f, frame_done one pulse, frame time 307200+32+small constant cycles.
REQ-033 fb_wr_ready=0 from cycle 10 for 500 cycles -> inflight+fifo_count peaks at exactly 64, no overflow assertion, fb_wr_valid and fb_wr_data stable, writes resume in order with no gaps or duplicates.
REQ-034 Random fb_wr_ready (50% duty) over full frame -> scoreboard exact; busy=1 throughout until frame_done.
REQ-035 Change camera inputs mid-frame, assert start again while busy -> rm_* shadows unchanged, second start ignored, single frame_done.
REQ-036 rst_n low for 1 cycle at write 1000 -> outputs match REQ-030 next cycle; new start yields a full, correct frame from address 0.
REQ-037 Check x wrap boundary at issue 639->640 -> rm_pixel (639,0) then (0,1); check the last issue is (639,479) followed by the DRAIN entry.

Source files
------------

// File: rtl/raymarch_frame_scheduler_if.sv
// Frame-buffer write port of the raymarch frame scheduler.
// The scheduler drives the master side and the frame buffer drives the slave side.
interface raymarch_frame_scheduler_if;
  logic        fb_wr_valid;
  logic        fb_wr_ready;
  logic [18:0] fb_wr_addr;
  logic [23:0] fb_wr_data;

  modport master (
    output fb_wr_valid,
    output fb_wr_addr,
    output fb_wr_data,
    input  fb_wr_ready
  );

  modport slave (
    input  fb_wr_valid,
    input  fb_wr_addr,
    input  fb_wr_data,
    output fb_wr_ready
  );
endinterface

// File: rtl/raymarch_frame_scheduler.sv
// Issues one frame of pixel coordinates to a fixed-latency raymarcher and streams
// the colour results in raster order to the frame buffer, with credit-based flow control.
module raymarch_frame_scheduler #(
  parameter int unsigned LATENCY    = 32,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [26:0] look_at_1_1,
  input  logic [26:0] look_at_1_2,
  input  logic [26:0] look_at_1_3,
  input  logic [26:0] look_at_2_1,
  input  logic [26:0] look_at_2_2,
  input  logic [26:0] look_at_2_3,
  input  logic [26:0] look_at_3_1,
  input  logic [26:0] look_at_3_2,
  input  logic [26:0] look_at_3_3,
  input  logic [26:0] eye_x,
  input  logic [26:0] eye_y,
  input  logic [26:0] eye_z,
  output logic        busy,
  output logic        frame_done,
  output logic [9:0]  rm_pixel_x,
  output logic [9:0]  rm_pixel_y,
  output logic [26:0] rm_look_at_1_1,
  output logic [26:0] rm_look_at_1_2,
  output logic [26:0] rm_look_at_1_3,
  output logic [26:0] rm_look_at_2_1,
  output logic [26:0] rm_look_at_2_2,
  output logic [26:0] rm_look_at_2_3,
  output logic [26:0] rm_look_at_3_1,
  output logic [26:0] rm_look_at_3_2,
  output logic [26:0] rm_look_at_3_3,
  output logic [26:0] rm_eye_x,
  output logic [26:0] rm_eye_y,
  output logic [26:0] rm_eye_z,
  input  logic [7:0]  rm_red,
  input  logic [7:0]  rm_green,
  input  logic [7:0]  rm_blue,
  raymarch_frame_scheduler_if.master fb
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW  = AW + 1;
  localparam int unsigned CW    = AW + 2;
  localparam int unsigned TOTAL = H_RES * V_RES;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state, state_next;
  logic                load, issue, last_pixel, credit_ok;
  logic [11:0][26:0]   cam_in, shadow;
  logic [9:0]          ix, iy;
  logic                issued;
  logic [LATENCY-1:0]  dly;
  logic [CW-1:0]       inflight;
  logic                push, pop;
  logic [23:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wptr, rptr;
  logic [CNTW-1:0]     fifo_count;
  logic [18:0]         wr_cnt;

  assign cam_in = {look_at_1_1, look_at_1_2, look_at_1_3,
                   look_at_2_1, look_at_2_2, look_at_2_3,
                   look_at_3_1, look_at_3_2, look_at_3_3,
                   eye_x, eye_y, eye_z};
  assign {rm_look_at_1_1, rm_look_at_1_2, rm_look_at_1_3,
          rm_look_at_2_1, rm_look_at_2_2, rm_look_at_2_3,
          rm_look_at_3_1, rm_look_at_3_2, rm_look_at_3_3,
          rm_eye_x, rm_eye_y, rm_eye_z} = shadow;

  // 'issued' marks the cycle a new coordinate is presented; it acts as the head of
  // the valid delay line so the tail lines up with the raymarcher's output.
  always_comb begin
    inflight = CW'(issued);
    for (int unsigned i = 0; i < LATENCY; i++) begin
      inflight = inflight + CW'(dly[i]);
    end
  end

  assign credit_ok  = (inflight + CW'(fifo_count)) < CW'(FIFO_DEPTH);
  assign last_pixel = (ix == 10'(H_RES - 1)) && (iy == 10'(V_RES - 1));
  assign push       = dly[LATENCY-1];
  assign pop        = fb.fb_wr_valid && fb.fb_wr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    issue      = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        issue = credit_ok;
        if (credit_ok && last_pixel) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (wr_cnt == 19'(TOTAL)) state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow     <= '0;
      ix         <= '0;
      iy         <= '0;
      rm_pixel_x <= '0;
      rm_pixel_y <= '0;
      issued     <= 1'b0;
      dly        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      wr_cnt     <= '0;
    end else begin
      issued <= issue;
      dly    <= (dly << 1) | LATENCY'(issued);
      if (issue) begin
        rm_pixel_x <= ix;
        rm_pixel_y <= iy;
        if (ix == 10'(H_RES - 1)) begin
          ix <= '0;
          iy <= iy + 10'd1;
        end else begin
          ix <= ix + 10'd1;
        end
      end
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr   <= rptr + AW'(1);
        wr_cnt <= wr_cnt + 19'd1;
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNTW'(1);
        2'b01:   fifo_count <= fifo_count - CNTW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (load) begin
        shadow <= cam_in;
        ix     <= '0;
        iy     <= '0;
        wr_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {rm_red, rm_green, rm_blue};
  end

  assign fb.fb_wr_valid = (fifo_count != '0);
  assign fb.fb_wr_data  = mem[rptr];
  assign fb.fb_wr_addr  = wr_cnt;

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (fifo_count == CNTW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_raymarch_frame_scheduler.sv
// Bench for raymarch_frame_scheduler on a reduced 40x16 frame: a stub raymarcher with a
// fixed delay feeds colour=f(x,y); writes are scoreboarded against the raster address map.
module tb_raymarch_frame_scheduler;
  localparam int unsigned LAT    = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned H      = 40;
  localparam int unsigned V      = 16;
  localparam int unsigned N      = H * V;
  localparam int unsigned BUDGET = 4 * N + 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, start;
  logic [11:0][26:0] cam_in, shadow_obs;
  logic [26:0] look_at_1_1, look_at_1_2, look_at_1_3, look_at_2_1, look_at_2_2, look_at_2_3;
  logic [26:0] look_at_3_1, look_at_3_2, look_at_3_3, eye_x, eye_y, eye_z;
  logic [26:0] rm_look_at_1_1, rm_look_at_1_2, rm_look_at_1_3, rm_look_at_2_1, rm_look_at_2_2;
  logic [26:0] rm_look_at_2_3, rm_look_at_3_1, rm_look_at_3_2, rm_look_at_3_3;
  logic [26:0] rm_eye_x, rm_eye_y, rm_eye_z;
  logic        busy, frame_done;
  logic [9:0]  rm_pixel_x, rm_pixel_y;
  logic [7:0]  rm_red, rm_green, rm_blue;
  logic [23:0] rm_pipe [LAT];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned exp_addr;

  raymarch_frame_scheduler_if fb_if ();

  raymarch_frame_scheduler #(
    .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .H_RES(H), .V_RES(V)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .look_at_1_1(look_at_1_1), .look_at_1_2(look_at_1_2), .look_at_1_3(look_at_1_3),
    .look_at_2_1(look_at_2_1), .look_at_2_2(look_at_2_2), .look_at_2_3(look_at_2_3),
    .look_at_3_1(look_at_3_1), .look_at_3_2(look_at_3_2), .look_at_3_3(look_at_3_3),
    .eye_x(eye_x), .eye_y(eye_y), .eye_z(eye_z),
    .busy(busy), .frame_done(frame_done),
    .rm_pixel_x(rm_pixel_x), .rm_pixel_y(rm_pixel_y),
    .rm_look_at_1_1(rm_look_at_1_1), .rm_look_at_1_2(rm_look_at_1_2),
    .rm_look_at_1_3(rm_look_at_1_3), .rm_look_at_2_1(rm_look_at_2_1),
    .rm_look_at_2_2(rm_look_at_2_2), .rm_look_at_2_3(rm_look_at_2_3),
    .rm_look_at_3_1(rm_look_at_3_1), .rm_look_at_3_2(rm_look_at_3_2),
    .rm_look_at_3_3(rm_look_at_3_3),
    .rm_eye_x(rm_eye_x), .rm_eye_y(rm_eye_y), .rm_eye_z(rm_eye_z),
    .rm_red(rm_red), .rm_green(rm_green), .rm_blue(rm_blue),
    .fb(fb_if)
  );

  assign {look_at_1_1, look_at_1_2, look_at_1_3, look_at_2_1, look_at_2_2, look_at_2_3,
          look_at_3_1, look_at_3_2, look_at_3_3, eye_x, eye_y, eye_z} = cam_in;
  assign shadow_obs = {rm_look_at_1_1, rm_look_at_1_2, rm_look_at_1_3,
                       rm_look_at_2_1, rm_look_at_2_2, rm_look_at_2_3,
                       rm_look_at_3_1, rm_look_at_3_2, rm_look_at_3_3,
                       rm_eye_x, rm_eye_y, rm_eye_z};

  function automatic logic [23:0] pix_colour(input int unsigned x, input int unsigned y);
    logic [7:0] r, g, b;
    r = 8'(x * 7 + 3);
    g = 8'(y * 13 + x);
    b = 8'(x ^ (y << 2));
    return {r, g, b};
  endfunction

  // Stub raymarcher: colour for the presented coordinate appears LAT cycles later.
  always @(posedge clk) begin
    rm_pipe[0] <= pix_colour(rm_pixel_x, rm_pixel_y);
    for (int i = 1; i < LAT; i++) rm_pipe[i] <= rm_pipe[i-1];
  end
  assign {rm_red, rm_green, rm_blue} = rm_pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_shadows(input string tag, input logic [11:0][26:0] exp);
    for (int i = 0; i < 12; i++) check(tag, 64'(shadow_obs[i]), 64'(exp[i]));
  endtask

  task automatic check_reset_state();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_valid", 64'(fb_if.fb_wr_valid), 64'd0);
    check("rst_addr", 64'(fb_if.fb_wr_addr), 64'd0);
    check("rst_px", 64'(rm_pixel_x), 64'd0);
    check("rst_py", 64'(rm_pixel_y), 64'd0);
    check_shadows("rst_shadow", '0);
  endtask

  // mode 0: ready high; 1: ready low for 500 cycles from cycle 10; 2: random ready;
  // 3: random ready with camera churn and a second start; 4: reset after 300 writes.
  task automatic run_frame(input int unsigned mode);
    logic [11:0][26:0] cam_exp;
    int unsigned k, t_done, peak, outst, old_idx, new_idx, extra_done, extra_busy, extra_valid;
    bit          done, saw_last, pv, pr;
    logic [23:0] pd;
    logic [18:0] pa;
    exp_addr = 0; peak = 0; t_done = 0; done = 0; saw_last = 0; pv = 0; pr = 0; pd = '0; pa = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) cam_exp[i] = 27'($urandom);
    cam_in = cam_exp;
    start = 1'b1;
    fb_if.fb_wr_ready = (mode >= 2 && mode <= 3) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    check("start_busy", 64'(busy), 64'd0);
    old_idx = int'(rm_pixel_y) * H + int'(rm_pixel_x);
    for (k = 1; k < BUDGET && !done; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (mode == 3) begin
        for (int i = 0; i < 12; i++) cam_in[i] = 27'($urandom);
        if (k == 200) start = 1'b1;
      end
      case (mode)
        1:       fb_if.fb_wr_ready = !(k >= 10 && k < 510);
        2, 3:    fb_if.fb_wr_ready = 1'($urandom_range(0, 1));
        default: fb_if.fb_wr_ready = 1'b1;
      endcase
      @(negedge clk);
      if (k == 2) check_shadows("shadow_load", cam_exp);
      new_idx = int'(rm_pixel_y) * H + int'(rm_pixel_x);
      if (new_idx != old_idx) begin
        check("issue_order", 64'(new_idx), 64'((old_idx + 1) % N));
        check("issue_after_last", 64'(saw_last), 64'd0);
        if (old_idx % H == H - 1 && old_idx != N - 1)
          check("x_wrap", {44'd0, rm_pixel_x, rm_pixel_y}, {54'd0, 10'(old_idx / H + 1)});
        if (new_idx == N - 1) saw_last = 1'b1;
        old_idx = new_idx;
      end
      check("busy", 64'(busy), 64'(!frame_done));
      if (pv && !pr) begin
        check("hold_valid", 64'(fb_if.fb_wr_valid), 64'd1);
        check("hold_data", 64'(fb_if.fb_wr_data), 64'(pd));
        check("hold_addr", 64'(fb_if.fb_wr_addr), 64'(pa));
      end
      if (mode == 1 && k >= 10 && k < 510) begin
        outst = new_idx + 1 - exp_addr;
        if (outst > peak) peak = outst;
      end
      if (fb_if.fb_wr_valid && fb_if.fb_wr_ready) begin
        check("wr_addr", 64'(fb_if.fb_wr_addr), 64'(exp_addr));
        check("wr_data", 64'(fb_if.fb_wr_data), 64'(pix_colour(exp_addr % H, exp_addr / H)));
        exp_addr++;
      end
      pv = fb_if.fb_wr_valid; pr = fb_if.fb_wr_ready;
      pd = fb_if.fb_wr_data;  pa = fb_if.fb_wr_addr;
      if (frame_done) begin
        done = 1'b1;
        t_done = k;
        check("writes_at_done", 64'(exp_addr), 64'(N));
        check("last_issued", 64'(saw_last), 64'd1);
      end
      if (mode == 4 && exp_addr == 300) break;
    end
    if (mode == 4) begin
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      check_reset_state();
      extra_valid = 0;
      repeat (50) begin
        @(posedge clk); #1; fb_if.fb_wr_ready = 1'b1;
        @(negedge clk);
        if (fb_if.fb_wr_valid || busy) extra_valid++;
      end
      check("write_after_reset", 64'(extra_valid), 64'd0);
      return;
    end
    check("frame_done_seen", 64'(done), 64'd1);
    if (mode == 0)
      check("frame_time", 64'(t_done >= N + LAT + 2 && t_done <= N + LAT + 8), 64'd1);
    if (mode == 1) check("credit_peak", 64'(peak), 64'(DEPTH));
    check_shadows("shadow_end", cam_exp);
    extra_done = 0; extra_busy = 0; extra_valid = 0;
    repeat (40) begin
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      if (frame_done) extra_done++;
      if (busy) extra_busy++;
      if (fb_if.fb_wr_valid) extra_valid++;
    end
    check("extra_done", 64'(extra_done), 64'd0);
    check("idle_busy", 64'(extra_busy), 64'd0);
    check("idle_valid", 64'(extra_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cam_in = '0;
    fb_if.fb_wr_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(4);
    run_frame(0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
